// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one half-adder pair processes WIDTH-bit operands LSB first
// under a start/busy/done handshake; the result is registered and held until the next start.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d;

  logic             s1, c1, c2, bit_s, carry_next;
  logic [WIDTH-1:0] res_shift;

  half_adder ha0 (.x(sha_q[0]), .y(shb_q[0]), .s(s1),    .c(c1));
  half_adder ha1 (.x(s1),       .y(carry_q),  .s(bit_s), .c(c2));

  assign carry_next = c1 | c2;
  // Truncating the widened shift keeps the WIDTH=1 case legal (no [0:1] slice).
  assign res_shift  = WIDTH'({bit_s, res_q} >> 1);

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = res_shift;
        sha_d   = sha_q >> 1;
        shb_d   = shb_q >> 1;
        carry_d = carry_next;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = res_shift;
          cout_d  = carry_next;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized checks of serial_adder_ctrl at WIDTH=8, plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, cin8, cout8, busy8, done8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, cout1, busy1, done1;
  logic [0:0] a1, b1, sum1;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt8 = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .cout(cout1), .busy(busy1), .done(done1)
  );

  always @(posedge clk) if (done8) done_cnt8++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launch one WIDTH=8 op from IDLE; operand inputs are scrambled right after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output int lat, output int busy_cnt);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = 1; busy_cnt = 0;
    while (!done8 && lat < 30) begin
      if (busy8) busy_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op1(input logic a, input logic b, input logic c, output int lat);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(negedge clk);
    start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
    lat = 1;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int   lat, bc, d0;
    logic [7:0] ra, rb;
    logic       rc;
    logic       held;
    logic [8:0] full;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    #12;
    chk("reset8 {sum,cout,busy,done}", {sum8, cout8, busy8, done8}, 11'h0);
    chk("reset1 {sum,cout,busy,done}", {sum1, cout1, busy1, done1}, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven basic additions
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt8;
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bc);
      chk($sformatf("vec%0d latency", i), lat, 9);
      chk($sformatf("vec%0d busy cycles", i), bc, 8);
      chk($sformatf("vec%0d sum", i), sum8, vecs[i].exp_sum);
      chk($sformatf("vec%0d cout", i), cout8, vecs[i].exp_cout);
      @(negedge clk);
      chk($sformatf("vec%0d done pulses", i), done_cnt8 - d0, 1);
      chk($sformatf("vec%0d sum held", i), sum8, vecs[i].exp_sum);
    end

    // start pulsed mid-RUN is ignored; operand changes mid-RUN have no effect
    d0 = done_cnt8;
    @(negedge clk); start8 = 1'b1; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(negedge clk); start8 = 1'b0; a8 = 8'h33;
    @(negedge clk); b8 = 8'h77;
    @(negedge clk); start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    chk("midrun sum keeps previous", sum8, 8'h47);
    @(negedge clk); start8 = 1'b0;
    lat = 4;
    while (!done8 && lat < 30) begin @(negedge clk); lat++; end
    chk("midrun latency", lat, 9);
    chk("midrun sum", sum8, 8'h30);
    chk("midrun cout", cout8, 1'b0);
    held = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sum8 !== 8'h30 || busy8 !== 1'b0) held = 1'b0;
    end
    chk("midrun done pulses", done_cnt8 - d0, 1);
    chk("idle hold 20 cycles", held, 1'b1);

    // Asynchronous reset mid-RUN aborts without a done pulse
    @(negedge clk); start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset {sum,cout,busy,done}", {sum8, cout8, busy8, done8}, 11'h0);
    d0 = done_cnt8;
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("no done after abort", done_cnt8 - d0, 0);
    chk("sum cleared after abort", sum8, 8'h00);
    op8(8'h01, 8'h01, 1'b0, lat, bc);
    chk("post-reset latency", lat, 9);
    chk("post-reset sum", sum8, 8'h02);

    // start held high: one result every WIDTH+2 cycles
    @(negedge clk); start8 = 1'b1; a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 40) start8 = 1'b0;
      if (k % 10 == 9) begin
        chk($sformatf("b2b c%0d {busy,done}", k), {busy8, done8}, 2'b01);
        chk($sformatf("b2b c%0d sum", k), sum8, 8'h03);
      end else if (k % 10 == 0) begin
        chk($sformatf("b2b c%0d {busy,done}", k), {busy8, done8}, 2'b00);
      end else begin
        chk($sformatf("b2b c%0d {busy,done}", k), {busy8, done8}, 2'b10);
      end
    end

    // WIDTH=1 instance: exhaustive
    op1(1'b1, 1'b1, 1'b1, lat);
    chk("w1 111 latency", lat, 2);
    chk("w1 111 {cout,sum}", {cout1, sum1}, 2'b11);
    for (int i = 0; i < 8; i++) begin
      op1(i[2], i[1], i[0], lat);
      chk($sformatf("w1 op%0d latency", i), lat, 2);
      chk($sformatf("w1 op%0d {cout,sum}", i), {cout1, sum1},
          2'(32'(i[2]) + 32'(i[1]) + 32'(i[0])));
    end

    // Randomized WIDTH=8 against a + b + cin
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      op8(ra, rb, rc, lat, bc);
      chk($sformatf("rand%0d %0h+%0h+%0h", i, ra, rb, rc), {lat[7:0], cout8, sum8},
          {8'd9, full});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
